// File: rtl/controlador_sequencia_perm.sv
// controlador_sequencia_perm: drives the permutation index generator and plays back its four indices
//
// Reduces a 16-bit seed to a permutation index 0..23, hands it to the generator,
// waits (bounded) for gen_ready_i, latches the 8-bit permutation and then shows
// p0..p3 one at a time: HOLD_CYCLES cycles valid, GAP_CYCLES cycles blank between.
//
// Ports:
//   clock_i          system clock, rising edge
//   reset_i          asynchronous active-low reset
//   start_i          request a new sequence (sampled only while idle)
//   semente_i        seed, only bits [4:0] are used
//   gen_entrada_o    registered generator input, [15:5]=0, [4:0]=reduced seed
//   gen_perm_i       generator result {p0,p1,p2,p3}, p0 in [7:6]
//   gen_ready_i      generator result valid (only looked at while waiting)
//   indice_o         index currently shown
//   indice_valido_o  high while indice_o is being shown
//   ocupado_o        high whenever the sequencer is not idle
//   pronto_o         one-cycle pulse when the sequence completes
//   erro_o           one-cycle pulse on generator timeout
//
// Optional build macro CONTROLADOR_VERIFICA_EN adds:
//   botoes_i         one-hot player buttons (already synchronized)
//   acerto_o         one-cycle pulse, together with pronto_o, after four correct presses
//   erro_jogada_o    one-cycle pulse on the first wrong press
// and replaces the completion step with a wait for the player to repeat p0..p3.
module controlador_sequencia_perm #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [15:0] semente_i,
    output logic [15:0] gen_entrada_o,
    input  logic [7:0]  gen_perm_i,
    input  logic        gen_ready_i,
`ifdef CONTROLADOR_VERIFICA_EN
    input  logic [3:0]  botoes_i,
    output logic        acerto_o,
    output logic        erro_jogada_o,
`endif
    output logic [1:0]  indice_o,
    output logic        indice_valido_o,
    output logic        ocupado_o,
    output logic        pronto_o,
    output logic        erro_o
);
    // One shared cycle counter serves the show, gap and timeout phases.
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES)
                        ? ((HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT)
                        : ((GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT);
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQUEST,
        S_WAIT_READY,
        S_SHOW,
        S_GAP,
        S_DONE,
        S_ERROR,
        S_WAIT_PLAY,
        S_ERRO_JOGADA
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pos_q, pos_d;
    logic [7:0]    perm_q, perm_d;
    logic [4:0]    entrada_q, entrada_d;
    logic [1:0]    indice_q, indice_d;
    logic          valido_q, ocupado_q, pronto_q, erro_q;
    logic [4:0]    semente_red;
    logic          unused_semente;

    // Fold 24..31 back onto 0..7 so the generator never sees its invalid range.
    assign semente_red    = (semente_i[4:0] >= 5'd24) ? semente_i[4:0] - 5'd24 : semente_i[4:0];
    assign unused_semente = ^semente_i[15:5];

    // Position 0 selects [7:6], position 3 selects [1:0].
    function automatic logic [1:0] campo(input logic [7:0] perm, input logic [1:0] pos);
        logic [7:0] sh;
        sh = perm << {pos, 1'b0};
        return sh[7:6];
    endfunction

`ifdef CONTROLADOR_VERIFICA_EN
    logic [3:0] botoes_prev_q;
    logic       acerto_q, acerto_d, erro_jogada_q;
    logic       press, press_ok;

    // A press is any rising bit; a multi-bit pattern can never match.
    assign press    = |(botoes_i & ~botoes_prev_q);
    assign press_ok = $onehot(botoes_i) &&
                      ({botoes_i[3] | botoes_i[2], botoes_i[3] | botoes_i[1]} == campo(perm_q, pos_q));
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        perm_d    = perm_q;
        entrada_d = entrada_q;
`ifdef CONTROLADOR_VERIFICA_EN
        acerto_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    entrada_d = semente_red;
                    state_d   = S_REQUEST;
                end
            end
            S_REQUEST: begin
                cnt_d   = '0;
                state_d = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (gen_ready_i) begin
                    perm_d  = gen_perm_i;
                    pos_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = S_SHOW;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHOW: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (pos_q != 2'd3) begin
                        state_d = S_GAP;
                    end else begin
`ifdef CONTROLADOR_VERIFICA_EN
                        pos_d   = 2'd0;
                        state_d = S_WAIT_PLAY;
`else
                        state_d = S_DONE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    pos_d   = pos_q + 2'd1;
                    state_d = S_SHOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
`ifdef CONTROLADOR_VERIFICA_EN
            S_WAIT_PLAY: begin
                if (press) begin
                    if (!press_ok) begin
                        state_d = S_ERRO_JOGADA;
                    end else if (pos_q == 2'd3) begin
                        acerto_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        pos_d = pos_q + 2'd1;
                    end
                end
            end
            S_ERRO_JOGADA: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
        // The shown index only changes when (re)entering SHOW; gaps and idle hold it.
        indice_d = (state_d == S_SHOW) ? campo(perm_d, pos_d) : indice_q;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pos_q     <= '0;
            perm_q    <= '0;
            entrada_q <= '0;
            indice_q  <= '0;
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            perm_q    <= perm_d;
            entrada_q <= entrada_d;
            indice_q  <= indice_d;
            valido_q  <= (state_d == S_SHOW);
            ocupado_q <= (state_d != S_IDLE);
            pronto_q  <= (state_d == S_DONE);
            erro_q    <= (state_d == S_ERROR);
        end
    end

`ifdef CONTROLADOR_VERIFICA_EN
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            botoes_prev_q <= '0;
            acerto_q      <= 1'b0;
            erro_jogada_q <= 1'b0;
        end else begin
            botoes_prev_q <= botoes_i;
            acerto_q      <= acerto_d;
            erro_jogada_q <= (state_d == S_ERRO_JOGADA);
        end
    end

    assign acerto_o      = acerto_q;
    assign erro_jogada_o = erro_jogada_q;
`endif

    assign gen_entrada_o   = {11'd0, entrada_q};
    assign indice_o        = indice_q;
    assign indice_valido_o = valido_q;
    assign ocupado_o       = ocupado_q;
    assign pronto_o        = pronto_q;
    assign erro_o          = erro_q;
endmodule

// File: tb/tb_controlador_sequencia_perm.sv
// tb_controlador_sequencia_perm: randomized self-checking bench with a cycle-timeline reference model
module tb_controlador_sequencia_perm;
    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        gen_ready = 1'b0;
    logic [15:0] semente = '0;
    logic [7:0]  gen_perm = '0;
    logic [15:0] gen_entrada;
    logic [1:0]  indice;
    logic        indice_valido, ocupado, pronto, erro;
`ifdef CONTROLADOR_VERIFICA_EN
    logic [3:0]  botoes = '0;
    logic        acerto, erro_jogada;
`endif

    int         checks = 0;
    int         passed = 0;
    logic [1:0] exp_ind = '0;

    // One entry per clock cycle after the start edge: what to drive and what to expect.
    typedef struct {
        bit          rdy_any;
        logic        rdy;
        logic [3:0]  bt;
        logic [15:0] ent;
        logic        val;
        logic [1:0]  ind;
        logic        ocu, pro, err, ace, ejo;
    } step_t;

    controlador_sequencia_perm #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clock_i        (clk),
        .reset_i        (rst_n),
        .start_i        (start),
        .semente_i      (semente),
        .gen_entrada_o  (gen_entrada),
        .gen_perm_i     (gen_perm),
        .gen_ready_i    (gen_ready),
`ifdef CONTROLADOR_VERIFICA_EN
        .botoes_i       (botoes),
        .acerto_o       (acerto),
        .erro_jogada_o  (erro_jogada),
`endif
        .indice_o       (indice),
        .indice_valido_o(indice_valido),
        .ocupado_o      (ocupado),
        .pronto_o       (pronto),
        .erro_o         (erro)
    );

    always #5 clk = ~clk;

    // d = cycles spent waiting before gen_ready (d >= TMO means never ready).
    // pr = player presses (4 nibbles, first press in [15:12]); 0 means the correct ones.
    task automatic run_seq(input logic [15:0] s, input logic [7:0] p, input int d, input bit launch,
                           input bit keep, input int pulse_t, input int abort_t, input logic [15:0] pr,
                           output int nval, output int npro, output int nerr, output int nace,
                           output int nejo, output logic [7:0] shown);
        step_t      q[$];
        step_t      e;
        int         r;
        logic [1:0] pi;
        logic       prev_val;
`ifdef CONTROLADOR_VERIFICA_EN
        logic [3:0] b;
        bit         ok;
`endif
        r = int'(s[4:0]);
        if (r >= 24) r -= 24;
        e = '{default: '0};
        e.rdy_any = 1'b1;
        e.ent     = 16'(r);
        e.ind     = exp_ind;
        e.ocu     = 1'b1;
        q.push_back(e);
        if (d >= TMO) begin
            e.rdy_any = 1'b0;
            for (int k = 0; k < TMO; k++) q.push_back(e);
            e.rdy_any = 1'b1;
            e.err     = 1'b1;
            q.push_back(e);
            e.err = 1'b0;
            e.ocu = 1'b0;
            q.push_back(e);
        end else begin
            e.rdy_any = 1'b0;
            for (int k = 0; k <= d; k++) begin
                e.rdy = (k == d);
                q.push_back(e);
            end
            e.rdy_any = 1'b1;
            e.rdy     = 1'b0;
            for (int i = 0; i < 4; i++) begin
                pi    = 2'(p >> (2 * (3 - i)));
                e.ind = pi;
                e.val = 1'b1;
                for (int k = 0; k < HOLD; k++) q.push_back(e);
                e.val = 1'b0;
                if (i < 3) for (int k = 0; k < GAP; k++) q.push_back(e);
            end
`ifdef CONTROLADOR_VERIFICA_EN
            for (int i = 0; i < 4; i++) begin
                pi   = 2'(p >> (2 * (3 - i)));
                b    = (pr == 16'd0) ? 4'(1 << pi) : 4'(pr >> (4 * (3 - i)));
                ok   = ($countones(b) == 1) && (b == 4'(1 << pi));
                e.bt = b;
                q.push_back(e);
                e.bt = 4'd0;
                if (!ok) begin
                    e.ejo = 1'b1;
                    q.push_back(e);
                    e.ejo = 1'b0;
                    e.ocu = 1'b0;
                    q.push_back(e);
                    break;
                end
                if (i == 3) begin
                    e.ace = 1'b1;
                    e.pro = 1'b1;
                    q.push_back(e);
                    e.ace = 1'b0;
                    e.pro = 1'b0;
                    e.ocu = 1'b0;
                    q.push_back(e);
                end else begin
                    q.push_back(e);
                end
            end
`else
            e.pro = 1'b1;
            q.push_back(e);
            e.pro = 1'b0;
            e.ocu = 1'b0;
            q.push_back(e);
`endif
            exp_ind = p[1:0];
        end
        if (abort_t >= 0) while (q.size() > abort_t + 1) void'(q.pop_back());
        nval = 0; npro = 0; nerr = 0; nace = 0; nejo = 0;
        shown = '0;
        prev_val = 1'b0;
        if (launch) begin
            @(negedge clk);
            start     = 1'b1;
            semente   = s;
            gen_perm  = p;
            gen_ready = 1'b0;
            @(posedge clk);
        end
        for (int t = 0; t < q.size(); t++) begin
            #1;
            start     = keep || (t == pulse_t);
            gen_ready = q[t].rdy_any ? 1'($urandom) : q[t].rdy;
            gen_perm  = q[t].rdy_any ? 8'($urandom) : p;
`ifdef CONTROLADOR_VERIFICA_EN
            botoes    = q[t].bt;
`endif
            @(negedge clk);
            checks++;
            if ({gen_entrada, indice_valido, indice, ocupado, pronto, erro} !==
                {q[t].ent, q[t].val, q[t].ind, q[t].ocu, q[t].pro, q[t].err})
                $display("FAIL seq t=%0d ent/val/ind/ocu/pro/err got %h/%b/%0d/%b/%b/%b required %h/%b/%0d/%b/%b/%b",
                         t, gen_entrada, indice_valido, indice, ocupado, pronto, erro,
                         q[t].ent, q[t].val, q[t].ind, q[t].ocu, q[t].pro, q[t].err);
            else passed++;
`ifdef CONTROLADOR_VERIFICA_EN
            checks++;
            if ({acerto, erro_jogada} !== {q[t].ace, q[t].ejo})
                $display("FAIL play t=%0d acerto/erro_jogada got %b/%b required %b/%b",
                         t, acerto, erro_jogada, q[t].ace, q[t].ejo);
            else passed++;
            nace += int'(acerto);
            nejo += int'(erro_jogada);
`endif
            if (indice_valido && !prev_val) shown = {shown[5:0], indice};
            prev_val = indice_valido;
            nval += int'(indice_valido);
            npro += int'(pronto);
            nerr += int'(erro);
            @(posedge clk);
        end
        #1;
        start     = keep;
        gen_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({gen_entrada, indice, indice_valido, ocupado, pronto, erro} !== 22'd0)
            $display("FAIL reset_async got %h/%0d/%b/%b/%b/%b required all zero",
                     gen_entrada, indice, indice_valido, ocupado, pronto, erro);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gen_entrada, indice, indice_valido, ocupado, pronto, erro} !== 22'd0)
            $display("FAIL reset_idle got %h/%0d/%b/%b/%b/%b required all zero",
                     gen_entrada, indice, indice_valido, ocupado, pronto, erro);
        else passed++;
    endtask

    task automatic test_basic();
        int nv, np, ne, na, nj;
        logic [7:0] sh;
        run_seq(16'h0009, 8'h6C, 0, 1'b1, 1'b0, -1, -1, 16'd0, nv, np, ne, na, nj, sh);
        checks++;
        if (gen_entrada !== 16'h0009) $display("FAIL basic_entrada got %h required 0009", gen_entrada);
        else passed++;
        checks++;
        if (sh !== 8'h6C) $display("FAIL basic_indices got %h required 6c", sh);
        else passed++;
        checks++;
        if (nv !== 4 * HOLD) $display("FAIL basic_valid_cycles got %0d required %0d", nv, 4 * HOLD);
        else passed++;
        checks++;
        if (np !== 1) $display("FAIL basic_pronto_count got %0d required 1", np);
        else passed++;
    endtask

    task automatic test_reduce();
        int nv, np, ne, na, nj;
        logic [7:0] sh;
        run_seq(16'h001F, 8'h4E, 0, 1'b1, 1'b0, -1, -1, 16'd0, nv, np, ne, na, nj, sh);
        checks++;
        if (gen_entrada !== 16'h0007) $display("FAIL reduce_31 got %h required 0007", gen_entrada);
        else passed++;
        checks++;
        if (sh !== 8'h4E) $display("FAIL reduce_indices got %h required 4e", sh);
        else passed++;
        run_seq(16'hFFF8, 8'h93, 1, 1'b1, 1'b0, -1, -1, 16'd0, nv, np, ne, na, nj, sh);
        checks++;
        if (gen_entrada !== 16'h0000) $display("FAIL reduce_24 got %h required 0000", gen_entrada);
        else passed++;
        run_seq(16'hA017, 8'h27, 2, 1'b1, 1'b0, -1, -1, 16'd0, nv, np, ne, na, nj, sh);
        checks++;
        if (gen_entrada !== 16'h0017) $display("FAIL reduce_23 got %h required 0017", gen_entrada);
        else passed++;
    endtask

    task automatic test_timeout();
        int nv, np, ne, na, nj;
        logic [7:0] sh;
        run_seq(16'h0003, 8'hE4, TMO, 1'b1, 1'b0, -1, -1, 16'd0, nv, np, ne, na, nj, sh);
        checks++;
        if (ne !== 1 || nv !== 0 || np !== 0)
            $display("FAIL timeout_counts got erro=%0d valid=%0d pronto=%0d required 1/0/0", ne, nv, np);
        else passed++;
        run_seq(16'h0005, 8'hD8, TMO - 1, 1'b1, 1'b0, -1, -1, 16'd0, nv, np, ne, na, nj, sh);
        checks++;
        if (ne !== 0 || np !== 1 || sh !== 8'hD8)
            $display("FAIL timeout_edge got erro=%0d pronto=%0d indices=%h required 0/1/d8", ne, np, sh);
        else passed++;
    endtask

    task automatic test_ignored_start();
        int nv, np, ne, na, nj;
        logic [7:0] sh;
        run_seq(16'h000C, 8'hB1, 0, 1'b1, 1'b0, 2 + HOLD + GAP + 1, -1, 16'd0, nv, np, ne, na, nj, sh);
        checks++;
        if (np !== 1 || sh !== 8'hB1)
            $display("FAIL ignored_start got pronto=%0d indices=%h required 1/b1", np, sh);
        else passed++;
    endtask

    task automatic test_abort();
        int nv, np, ne, na, nj;
        logic [7:0] sh;
        run_seq(16'h0011, 8'h6C, 0, 1'b1, 1'b0, -1, 2 + HOLD, 16'd0, nv, np, ne, na, nj, sh);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gen_entrada, indice, indice_valido, ocupado, pronto, erro} !== 22'd0)
            $display("FAIL abort_immediate got %h/%0d/%b/%b/%b/%b required all zero",
                     gen_entrada, indice, indice_valido, ocupado, pronto, erro);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if ({ocupado, pronto, erro} !== 3'b000)
            $display("FAIL abort_held got ocupado/pronto/erro %b/%b/%b required 0/0/0", ocupado, pronto, erro);
        else passed++;
        rst_n   = 1'b1;
        exp_ind = 2'd0;
        run_seq(16'h0000, 8'h1B, 0, 1'b1, 1'b0, -1, -1, 16'd0, nv, np, ne, na, nj, sh);
        checks++;
        if (sh !== 8'h1B || np !== 1)
            $display("FAIL abort_restart got indices=%h pronto=%0d required 1b/1", sh, np);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int nv, np, ne, na, nj;
        logic [7:0] sh;
        run_seq(16'h0015, 8'h39, 1, 1'b1, 1'b1, -1, -1, 16'd0, nv, np, ne, na, nj, sh);
        checks++;
        if (np !== 1) $display("FAIL b2b_first_pronto got %0d required 1", np);
        else passed++;
        run_seq(16'h0015, 8'h8D, 0, 1'b0, 1'b0, -1, -1, 16'd0, nv, np, ne, na, nj, sh);
        checks++;
        if (np !== 1 || sh !== 8'h8D)
            $display("FAIL b2b_second got pronto=%0d indices=%h required 1/8d", np, sh);
        else passed++;
    endtask

    task automatic test_random();
        int nv, np, ne, na, nj;
        logic [7:0]  sh;
        logic [15:0] s;
        logic [7:0]  p;
        int          d;
        for (int it = 0; it < 8; it++) begin
            s = 16'($urandom);
            if (it % 2 == 0) s[4:0] = 5'(24 + $urandom_range(0, 7));
            p = 8'($urandom);
            d = (it % 4 == 3) ? TMO : $urandom_range(0, 5);
            run_seq(s, p, d, 1'b1, 1'b0, -1, -1, 16'd0, nv, np, ne, na, nj, sh);
            checks++;
            if (ne !== int'(d >= TMO))
                $display("FAIL random_err it=%0d got %0d required %0d", it, ne, int'(d >= TMO));
            else passed++;
        end
    endtask

`ifdef CONTROLADOR_VERIFICA_EN
    task automatic test_play();
        int nv, np, ne, na, nj;
        logic [7:0] sh;
        run_seq(16'h0009, 8'h6C, 0, 1'b1, 1'b0, -1, -1, 16'h2481, nv, np, ne, na, nj, sh);
        checks++;
        if (na !== 1 || np !== 1 || nj !== 0)
            $display("FAIL play_ok got acerto=%0d pronto=%0d erro_jogada=%0d required 1/1/0", na, np, nj);
        else passed++;
        run_seq(16'h0009, 8'h6C, 0, 1'b1, 1'b0, -1, -1, 16'h2100, nv, np, ne, na, nj, sh);
        checks++;
        if (nj !== 1 || np !== 0 || na !== 0)
            $display("FAIL play_wrong got erro_jogada=%0d pronto=%0d acerto=%0d required 1/0/0", nj, np, na);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reduce();
        test_timeout();
        test_ignored_start();
        test_abort();
        test_back_to_back();
        test_random();
`ifdef CONTROLADOR_VERIFICA_EN
        test_play();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
